data_ram_ls: RTL and testbench
==============================

# data_ram_ls

Parametrised single-port data memory for the CPU's MEM stage. It replaces the fixed 32-word, word-only data RAM with a configurable depth, byte/halfword/word stores with lane masking, and sign- or zero-extended loads. It has a registered one-cycle read path with a valid strobe, alignment checking, and a hardware clear sequence after reset, so no simulation-only initialisation is needed. It is driven directly by the load/store unit.

## Interface
Parameters:
- DEPTH, 32, number of 32-bit words; power of two, ≥ 2. Index width AW = clog2(DEPTH).
- CLEAR_ON_RESET, 1, when 1 the block zeroes every word after reset before accepting requests.

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- req  in  1  request valid; the request is accepted on an edge where req=1 and ready=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- uns  in  1  load extension: 1 = zero-extend, 0 = sign-extend. Ignored for word loads and for stores.
- addr  in  32  byte address. Word index = addr[AW+1:2]; higher bits are ignored, so addresses wrap modulo 4·DEPTH.
- wdata  in  32  store data; the byte/halfword value is taken from bits [7:0] or [15:0].
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle pulse marking the response to an accepted load or to an erroring request.
- rdata  out  32  extended load data; valid only when rvalid=1.
- err  out  1  one-cycle pulse, coincident with rvalid, flagging a misaligned or reserved-size request.

## Operation
- State machine has two states:
  - CLEAR: counter walks words 0..DEPTH-1, writing 0 to one word per cycle. ready=0.
  - RUN: ready=1 every cycle.
- State transitions:
  - Reset enters CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
  - CLEAR → RUN on the edge that writes word DEPTH-1.
- Lanes are little-endian: byte k = bits [8k+7:8k].
- Store lane mapping:
  - Byte store writes only lane addr[1:0].
  - Halfword store writes lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all four lanes.
  - Unwritten lanes keep their value.
- Load extraction:
  - The word is read at acceptance and registered.
  - The selected byte or halfword is extended to 32 bits according to uns.
- Alignment rules:
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]≠00 is an error.
  - size=11 is always an error.
- Error handling:
  - The request is still accepted and memory is not modified.
  - One cycle later rvalid=1, err=1 and rdata=0, for both loads and stores.
- Successful stores produce no rvalid.
- Only one request is accepted per cycle. There is no back-pressure on responses; the consumer must take rvalid when it occurs.

## Timing
- Reset values: ready=0, rvalid=0, rdata=0, err=0, clear counter=0, state as above.
- Memory contents are not reset asynchronously. They are valid only after CLEAR completes, or are left undefined when CLEAR_ON_RESET=0.
- CLEAR duration: after Resetn rises, ready rises exactly DEPTH cycles after the first rising edge. With CLEAR_ON_RESET=0, ready rises after the first edge.
- Load latency is 1: a load accepted at edge N has rvalid/rdata valid during the cycle after edge N and is cleared at edge N+1 unless another load is accepted.
- Back-to-back loads give back-to-back rvalid pulses.
- A store at edge N followed by a load of the same word at edge N+1 returns the new data.
- req asserted while ready=0 is ignored; nothing is queued.
- Reset asserted mid-CLEAR or with a response pending: outputs drop to their reset values immediately, and CLEAR restarts from word 0.

## Test plan
- Clear sequence, DEPTH=32, CLEAR_ON_RESET=1: release Resetn and hold req=1 → ready=0 for 32 cycles then 1. Word loads of addresses 0x00..0x7C all return 0x00000000.
- Byte/half stores: SW 0x11223344 @0x10, SB 0xAA @0x11, SH 0xBEEF @0x12 → LW @0x10 = 0xBEEFAA44.
- Extension: word @0x20 = 0x80FF7F01.
  - LB @0x22 = 0xFFFFFFFF; LBU @0x22 = 0x000000FF.
  - LH @0x22 = 0xFFFF80FF; LHU @0x20 = 0x00007F01.
  - LB @0x20 = 0x00000001.
- Misalignment: SW 0xDEADBEEF @0x24, then SH @0x25 and LW @0x26 → each gives rvalid=1, err=1, rdata=0 one cycle later. LW @0x24 still returns 0xDEADBEEF. size=11 also gives err.
- Wrap and back-to-back:
  - SW 0x12345678 @0x80 with DEPTH=32 → LW @0x00 = 0x12345678.
  - Three consecutive loads → three consecutive rvalid pulses, in order.
- Reset mid-operation: assert Resetn=0 at clear counter 10, or with a load response pending → rvalid/err/ready go 0 immediately. After release, a full 32-cycle CLEAR is repeated.

Source files
------------

// File: rtl/data_ram_ls.sv
// data_ram_ls: parametrised single-port data memory for the MEM stage.
// Supports byte/halfword/word stores with lane masks and sign/zero-extended
// loads. The read path is registered with one cycle of latency. After reset
// a sequencer can clear every word before the block accepts requests.
module data_ram_ls #(
  parameter int unsigned DEPTH          = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_d, rvalid_d, err_d;
  logic [31:0]     rdata_d;

  logic [31:0]     mem [DEPTH];
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [AW-1:0]   mem_idx;
  logic [31:0]     mem_wd;

  logic [AW-1:0]   addr_idx_c;
  logic            accept_c;
  logic            bad_c;
  logic [3:0]      st_be_c;
  logic [31:0]     st_wd_c;
  logic [31:0]     rd_word_c;
  logic [7:0]      rd_byte_c;
  logic [15:0]     rd_half_c;
  logic [31:0]     ld_data_c;

  // Address bits above the word index are deliberately ignored (wrap).
  logic            unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign addr_idx_c = addr[AW+1:2];
  assign accept_c   = req & ready;
  assign rd_word_c  = mem[addr_idx_c];

  // Misaligned halfword/word or reserved size.
  always_comb begin
    bad_c = 1'b0;
    case (size)
      2'b00:   bad_c = 1'b0;
      2'b01:   bad_c = addr[0];
      2'b10:   bad_c = (addr[1:0] != 2'b00);
      default: bad_c = 1'b1;
    endcase
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    st_be_c = 4'hF;
    st_wd_c = wdata;
    case (size)
      2'b00: begin
        st_be_c = 4'b0001 << addr[1:0];
        st_wd_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be_c = addr[1] ? 4'b1100 : 4'b0011;
        st_wd_c = {2{wdata[15:0]}};
      end
      default: begin
        st_be_c = 4'hF;
        st_wd_c = wdata;
      end
    endcase
  end

  // Load lane selection and extension.
  always_comb begin
    rd_byte_c = rd_word_c[7:0];
    case (addr[1:0])
      2'd0: rd_byte_c = rd_word_c[7:0];
      2'd1: rd_byte_c = rd_word_c[15:8];
      2'd2: rd_byte_c = rd_word_c[23:16];
      2'd3: rd_byte_c = rd_word_c[31:24];
    endcase
    rd_half_c = addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    ld_data_c = rd_word_c;
    case (size)
      2'b00:   ld_data_c = uns ? {24'h0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
      2'b01:   ld_data_c = uns ? {16'h0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
      default: ld_data_c = rd_word_c;
    endcase
  end

  // State, clear counter and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= ready_d;
      rvalid  <= rvalid_d;
      err     <= err_d;
      rdata   <= rdata_d;
    end
  end

  // Next-state, memory write control and next output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = 32'h0;
    mem_we   = 1'b0;
    mem_be   = 4'h0;
    mem_idx  = addr_idx_c;
    mem_wd   = 32'h0;
    case (state_q)
      ST_CLEAR: begin
        mem_we  = 1'b1;
        mem_be  = 4'hF;
        mem_idx = cnt_q;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        if (accept_c) begin
          if (bad_c) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else if (we) begin
            mem_we = 1'b1;
            mem_be = st_be_c;
            mem_wd = st_wd_c;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = ld_data_c;
          end
        end
      end
    endcase
  end

  // Storage array with byte-lane write enables; not reset.
  always_ff @(posedge Clock) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we && mem_be[k]) begin
        mem[mem_idx][8*k +: 8] <= mem_wd[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ls.sv
// Directed self-checking bench for data_ram_ls (DEPTH=32, clear on reset).
module tb_data_ram_ls;

  logic        Clock;
  logic        Resetn;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int vectors;
  int miscompares;

  data_ram_ls #(.DEPTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .req    (req),
    .we     (we),
    .size   (size),
    .uns    (uns),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request at the next edge; checks the response after that edge.
  task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic ev, input logic ee, input logic [31:0] ed);
    @(negedge Clock);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge Clock);
    #1;
    req = 1'b0;
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(ev));
    chk({tag, ".err"}, 32'(err), 32'(ee));
    if (ev) chk({tag, ".rdata"}, rdata, ed);
  endtask

  task automatic lw(input string tag, input logic [31:0] a, input logic [31:0] exp);
    xfer(tag, 1'b0, 2'b10, 1'b0, a, 32'h0, 1'b1, 1'b0, exp);
  endtask

  task automatic sw(input string tag, input logic [31:0] a, input logic [31:0] d);
    xfer(tag, 1'b1, 2'b10, 1'b0, a, d, 1'b0, 1'b0, 32'h0);
  endtask

  // Called just after Resetn rises (at a falling edge): ready low for 32 edges.
  task automatic wait_clear(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(posedge Clock);
      #1;
      chk({tag, ".ready_low"}, 32'(ready), 32'h0);
    end
    @(posedge Clock);
    #1;
    chk({tag, ".ready_high"}, 32'(ready), 32'h1);
    req = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Resetn = 1'b0;
    // A store held during CLEAR must be ignored.
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'hFFFFFFFF;
    #12;
    chk("rst.ready", 32'(ready), 32'h0);
    chk("rst.rvalid", 32'(rvalid), 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    wait_clear("clear1");

    for (int i = 0; i < 32; i++) lw("zero", 32'(i * 4), 32'h0);

    // Byte and halfword stores over a word.
    sw("sw10", 32'h10, 32'h11223344);
    xfer("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 1'b0, 1'b0, 32'h0);
    xfer("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 1'b0, 1'b0, 32'h0);
    lw("lw10", 32'h10, 32'hBEEFAA44);

    // Extension.
    sw("sw20", 32'h20, 32'h80FF7F01);
    xfer("lb22",  1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF);
    xfer("lbu22", 1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 1'b1, 1'b0, 32'h000000FF);
    xfer("lh22",  1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1, 1'b0, 32'hFFFF80FF);
    xfer("lhu20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 32'h00007F01);
    xfer("lb20",  1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h00000001);
    xfer("lb23",  1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80);
    xfer("lbu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b1, 1'b0, 32'h0000007F);
    xfer("lh20",  1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h00007F01);

    // Misalignment and reserved size.
    sw("sw24", 32'h24, 32'hDEADBEEF);
    xfer("sh25",   1'b1, 2'b01, 1'b0, 32'h25, 32'h00001234, 1'b1, 1'b1, 32'h0);
    xfer("lw26",   1'b0, 2'b10, 1'b0, 32'h26, 32'h0, 1'b1, 1'b1, 32'h0);
    xfer("ld11",   1'b0, 2'b11, 1'b0, 32'h24, 32'h0, 1'b1, 1'b1, 32'h0);
    xfer("st11",   1'b1, 2'b11, 1'b0, 32'h24, 32'h0, 1'b1, 1'b1, 32'h0);
    xfer("sw27",   1'b1, 2'b10, 1'b0, 32'h27, 32'h0, 1'b1, 1'b1, 32'h0);
    lw("lw24", 32'h24, 32'hDEADBEEF);

    // Address wrap modulo 4*DEPTH.
    sw("sw80", 32'h80, 32'h12345678);
    lw("lw00", 32'h00, 32'h12345678);

    // Store then load on the next edge, then back-to-back loads.
    @(negedge Clock);
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(posedge Clock); #1;
    chk("b2b.st_rvalid", 32'(rvalid), 32'h0);
    we = 1'b0; addr = 32'h30;
    @(posedge Clock); #1;
    chk("b2b.rv0", 32'(rvalid), 32'h1);
    chk("b2b.rd0", rdata, 32'hCAFEF00D);
    addr = 32'h10;
    @(posedge Clock); #1;
    chk("b2b.rv1", 32'(rvalid), 32'h1);
    chk("b2b.rd1", rdata, 32'hBEEFAA44);
    addr = 32'h20;
    @(posedge Clock); #1;
    chk("b2b.rv2", 32'(rvalid), 32'h1);
    chk("b2b.rd2", rdata, 32'h80FF7F01);
    addr = 32'h24;
    @(posedge Clock); #1;
    chk("b2b.rv3", 32'(rvalid), 32'h1);
    chk("b2b.rd3", rdata, 32'hDEADBEEF);
    req = 1'b0;
    @(posedge Clock); #1;
    chk("b2b.idle", 32'(rvalid), 32'h0);

    // Reset with an error response pending.
    xfer("pend", 1'b1, 2'b01, 1'b0, 32'h25, 32'h0, 1'b1, 1'b1, 32'h0);
    #2;
    Resetn = 1'b0;
    #1;
    chk("rstpend.rvalid", 32'(rvalid), 32'h0);
    chk("rstpend.err", 32'(err), 32'h0);
    chk("rstpend.ready", 32'(ready), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    wait_clear("clear2");
    lw("post2", 32'h10, 32'h0);

    // Reset when the clear counter has reached 10.
    sw("sw24b", 32'h24, 32'h5A5A5A5A);
    @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (10) @(posedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    chk("rstmid.ready", 32'(ready), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    wait_clear("clear3");
    lw("post3", 32'h24, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
